// File: rtl/genram_arbiter.sv
// Two-requester arbiter/sequencer for a single-port registered-read genram, with locked bursts.
// Optional macro GENRAM_ARB_RR_EN selects round-robin on conflict (default: req0 fixed priority).
module genram_arbiter #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_wr,
  output logic          ram_rd,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic          gnt_any;
  logic          sel_we;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic          rd_pend;
  logic          rd_tag;
`ifdef GENRAM_ARB_RR_EN
  logic          rr_ptr;
`endif

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
`ifdef GENRAM_ARB_RR_EN
            // pointer holds the last winner, so the other side wins the conflict
            if (rr_ptr) gnt0 = 1'b1;
            else        gnt1 = 1'b1;
`else
            gnt0 = 1'b1;
`endif
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
          if (gnt0 && lock0)      state_nxt = OWN0;
          else if (gnt1 && lock1) state_nxt = OWN1;
        end
        // owner dropping its request releases the RAM without a grant this cycle
        OWN0: begin
          gnt0 = req0;
          if (!req0 || !lock0) state_nxt = IDLE;
        end
        OWN1: begin
          gnt1 = req1;
          if (!req1 || !lock1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign gnt_any  = gnt0 | gnt1;
  assign sel_we   = gnt1 ? we1 : we0;
  assign ram_wr   = gnt_any & sel_we;
  assign ram_rd   = gnt_any & ~sel_we;
  assign ram_addr = gnt_any ? (gnt1 ? addr1 : addr0) : addr_q;
  assign ram_din  = gnt_any ? (gnt1 ? wdata1 : wdata0) : din_q;

  // rst in the return cycle squashes the pending read
  assign rvalid0 = rd_pend & ~rd_tag & ~rst;
  assign rvalid1 = rd_pend &  rd_tag & ~rst;
  assign rdata0  = ram_dout;
  assign rdata1  = ram_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      rd_pend <= 1'b0;
      rd_tag  <= 1'b0;
`ifdef GENRAM_ARB_RR_EN
      rr_ptr  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      rd_pend <= ram_rd;
      rd_tag  <= gnt1;
      if (gnt_any) begin
        addr_q <= ram_addr;
        din_q  <= ram_din;
`ifdef GENRAM_ARB_RR_EN
        rr_ptr <= gnt1;
`endif
      end
    end
  end

endmodule
